float64_mul_sig_core: RTL

- Upstream stage of the float64 multiplier. It feeds roundAndPackFloat64.
- Accepts two IEEE-754 binary64 operands and decodes special cases: NaN, infinity, zero.
- Normalizes subnormal operands, then forms the 128-bit significand product with a multi-cycle 64x16 shift-accumulate datapath.
- Presents either unrounded zSign/zExp/zSig for the round-and-pack stage, or a fully packed bypass result with exception flags.

---
 rtl/float64_mul_sig_core_pkg.sv | 42 ++++
 rtl/float64_mul_sig_core_if.sv | 32 +++
 rtl/float64_mul_sig_core_normalize.sv | 27 ++
 rtl/float64_mul_sig_core.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/float64_mul_sig_core_pkg.sv
// Shared constants, state encoding and operand classification for the
// float64 significand-multiply front end.
package float64_pkg;

    localparam int MUL_CHUNK = 16;
    localparam int MUL_STEPS = 64 / MUL_CHUNK;

    localparam logic [31:0] FLAG_INEXACT   = 32'd1;
    localparam logic [31:0] FLAG_UNDERFLOW = 32'd2;
    localparam logic [31:0] FLAG_OVERFLOW  = 32'd4;
    localparam logic [31:0] FLAG_DIVBYZERO = 32'd8;
    localparam logic [31:0] FLAG_INVALID   = 32'd16;

    localparam logic [63:0] DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [12:0] EXP_BIAS    = 13'd1023;
    localparam logic [10:0] EXP_MAX     = 11'h7FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_MUL,
        ST_FIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_inf;
        logic is_zero;
    } fclass_t;

    function automatic fclass_t classify(input logic [63:0] x);
        fclass_t c;
        c.is_nan  = (x[62:52] == EXP_MAX) && (x[51:0] != 52'd0);
        c.is_snan = c.is_nan && !x[51];
        c.is_inf  = (x[62:52] == EXP_MAX) && (x[51:0] == 52'd0);
        c.is_zero = (x[62:0] == 63'd0);
        return c;
    endfunction

endpackage

// File: rtl/float64_mul_sig_core_if.sv
// Start/done handshake, operands, flags and unrounded/bypass results of the
// float64 significand-multiply stage.
interface float64_mul_sig_core_if;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] float_exception_flag_i;
    logic [31:0] float_exception_flag_o;
    logic        float_exception_flag_o_ap_vld;
    logic        zSign;
    logic [12:0] zExp;
    logic [63:0] zSig;
    logic        bypass;
    logic [63:0] ap_return_bypass;

    modport master (
        output ap_start, a, b, float_exception_flag_i,
        input  ap_done, ap_idle, ap_ready, float_exception_flag_o,
               float_exception_flag_o_ap_vld, zSign, zExp, zSig, bypass,
               ap_return_bypass
    );

    modport slave (
        input  ap_start, a, b, float_exception_flag_i,
        output ap_done, ap_idle, ap_ready, float_exception_flag_o,
               float_exception_flag_o_ap_vld, zSign, zExp, zSig, bypass,
               ap_return_bypass
    );
endinterface

// File: rtl/float64_mul_sig_core_normalize.sv
// Subnormal normalisation: shifts the fraction so its leading one lands on the
// hidden-bit position (bit 52) and returns the matching 13-bit exponent.
module normalize_subnormal64 (
    input  logic [51:0] frac,
    output logic [63:0] sig,
    output logic [12:0] exp13
);
    logic [63:0] x;
    logic [6:0]  lz;
    logic [6:0]  sc;

    assign x = {12'd0, frac};

    // Ascending scan: the highest set bit is the last to overwrite lz.
    always_comb begin
        lz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) begin
                lz = 7'(63 - i);
            end
        end
    end

    assign sc    = lz - 7'd11;
    assign sig   = x << sc;
    assign exp13 = 13'd1 - {6'd0, sc};
endmodule

// File: rtl/float64_mul_sig_core.sv
// float64 multiply front end: special-case bypass, operand normalisation and a
// 64x16 shift-accumulate significand product feeding round-and-pack.
module float64_mul_sig_core
    import float64_pkg::*;
(
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    float64_mul_sig_core_if.slave  bus
);
    state_t         state_reg;
    logic [62:0]    a_reg;
    logic [62:0]    b_reg;
    logic [31:0]    flag_in_reg;
    logic [31:0]    raised_reg;
    logic [63:0]    a_sig_reg;
    logic [63:0]    b_sig_reg;
    logic [12:0]    exp_reg;
    logic [127:0]   acc_reg;
    logic [1:0]     cnt_reg;
    logic           done_reg;
    logic           vld_reg;
    logic           zsign_reg;
    logic [12:0]    zexp_reg;
    logic [63:0]    zsig_reg;
    logic           bypass_reg;
    logic [63:0]    ret_reg;

    fclass_t        cls_a;
    fclass_t        cls_b;
    logic           special;
    logic [63:0]    spec_res;
    logic [31:0]    spec_flags;
    logic           prod_sign;

    always_comb begin
        cls_a      = classify(bus.a);
        cls_b      = classify(bus.b);
        prod_sign  = bus.a[63] ^ bus.b[63];
        special    = cls_a.is_nan | cls_b.is_nan | cls_a.is_inf | cls_b.is_inf
                   | cls_a.is_zero | cls_b.is_zero;
        spec_res   = 64'd0;
        spec_flags = 32'd0;
        if (cls_a.is_nan || cls_b.is_nan) begin
            spec_res = (cls_a.is_nan ? bus.a : bus.b) | (64'd1 << 51);
            if (cls_a.is_snan || cls_b.is_snan) begin
                spec_flags = FLAG_INVALID;
            end
        end else if ((cls_a.is_inf && cls_b.is_zero) || (cls_a.is_zero && cls_b.is_inf)) begin
            spec_res   = DEFAULT_NAN;
            spec_flags = FLAG_INVALID;
        end else if (cls_a.is_inf || cls_b.is_inf) begin
            spec_res = {prod_sign, EXP_MAX, 52'd0};
        end else begin
            spec_res = {prod_sign, 63'd0};
        end
    end

    logic [62:0] op_word [2];
    logic [63:0] op_sig  [2];
    logic [12:0] op_exp  [2];

    assign op_word[0] = a_reg;
    assign op_word[1] = b_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_norm
            logic [63:0] sub_sig;
            logic [12:0] sub_exp;
            logic        is_sub;

            normalize_subnormal64 u_norm (
                .frac  (op_word[gi][51:0]),
                .sig   (sub_sig),
                .exp13 (sub_exp)
            );

            // Zero operands never reach NORM, so exp==0 here means subnormal.
            assign is_sub      = (op_word[gi][62:52] == 11'd0);
            assign op_sig[gi]  = is_sub ? sub_sig : {11'd0, 1'b1, op_word[gi][51:0]};
            assign op_exp[gi]  = is_sub ? sub_exp : {2'd0, op_word[gi][62:52]};
        end
    endgenerate

    logic [79:0]  mul_prod;
    logic [127:0] mul_term;
    logic [63:0]  fin_sig;
    logic         fin_norm;

    // b_sig_reg is shifted down each MUL cycle, so its low chunk is always current.
    assign mul_prod = {16'd0, a_sig_reg} * {64'd0, b_sig_reg[MUL_CHUNK-1:0]};
    assign mul_term = {48'd0, mul_prod} << {cnt_reg, 4'd0};
    assign fin_sig  = acc_reg[127:64] | {63'd0, (acc_reg[63:0] != 64'd0)};
    assign fin_norm = ~fin_sig[63] & ~fin_sig[62];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            flag_in_reg <= '0;
            raised_reg  <= '0;
            a_sig_reg   <= '0;
            b_sig_reg   <= '0;
            exp_reg     <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            vld_reg     <= 1'b0;
            zsign_reg   <= 1'b0;
            zexp_reg    <= '0;
            zsig_reg    <= '0;
            bypass_reg  <= 1'b0;
            ret_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            vld_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ap_start) begin
                        a_reg       <= bus.a[62:0];
                        b_reg       <= bus.b[62:0];
                        flag_in_reg <= bus.float_exception_flag_i;
                        zsign_reg   <= prod_sign;
                        zexp_reg    <= '0;
                        zsig_reg    <= '0;
                        if (special) begin
                            bypass_reg <= 1'b1;
                            ret_reg    <= spec_res;
                            raised_reg <= spec_flags;
                            done_reg   <= 1'b1;
                            vld_reg    <= (spec_flags != 32'd0);
                            state_reg  <= ST_DONE;
                        end else begin
                            bypass_reg <= 1'b0;
                            ret_reg    <= '0;
                            raised_reg <= '0;
                            state_reg  <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    a_sig_reg <= op_sig[0] << 10;
                    b_sig_reg <= op_sig[1] << 11;
                    exp_reg   <= op_exp[0] + op_exp[1] - EXP_BIAS;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= ST_MUL;
                end
                ST_MUL: begin
                    acc_reg   <= acc_reg + mul_term;
                    b_sig_reg <= b_sig_reg >> MUL_CHUNK;
                    cnt_reg   <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'(MUL_STEPS - 1)) begin
                        state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    zsig_reg  <= fin_norm ? (fin_sig << 1) : fin_sig;
                    zexp_reg  <= fin_norm ? (exp_reg - 13'd1) : exp_reg;
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ap_done                       = done_reg;
    assign bus.ap_ready                      = done_reg;
    assign bus.ap_idle                       = (state_reg == ST_IDLE) && !bus.ap_start;
    assign bus.float_exception_flag_o        = (state_reg == ST_DONE) ? (flag_in_reg | raised_reg)
                                                                      : bus.float_exception_flag_i;
    assign bus.float_exception_flag_o_ap_vld = vld_reg;
    assign bus.zSign                         = zsign_reg;
    assign bus.zExp                          = zexp_reg;
    assign bus.zSig                          = zsig_reg;
    assign bus.bypass                        = bypass_reg;
    assign bus.ap_return_bypass              = ret_reg;
endmodule
